// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with level flags, read-valid and sticky error flags
// Optional first-word-fall-through read port: define SYNC_FIFO_FWFT_EN
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   wr_en, wr_data    write request and data
//   rd_en             read request (pop/acknowledge in FWFT mode)
//   rd_data, rd_valid read data and its valid flag
//   full, empty       count == DEPTH, count == 0
//   almost_full       count >= AF_LEVEL
//   almost_empty      count <= AE_LEVEL
//   count             occupancy 0..DEPTH
//   overflow          sticky: write attempted while full
//   underflow         sticky: read attempted while empty
//   err_clr           clears overflow/underflow (a new error in the same cycle wins)
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              wr_acc, rd_acc;

    assign full         = count == (AW+1)'(DEPTH);
    assign empty        = count == '0;
    assign almost_full  = count >= (AW+1)'(AF_LEVEL);
    assign almost_empty = count <= (AW+1)'(AE_LEVEL);
    assign wr_acc       = wr_en & ~full;
    assign rd_acc       = rd_en & ~empty;

    always_ff @(posedge clk)
        if (wr_acc) mem[wr_ptr] <= wr_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            if (wr_acc & ~rd_acc) count <= count + 1'b1;
            else if (rd_acc & ~wr_acc) count <= count - 1'b1;
            overflow  <= (wr_en & full) | (overflow & ~err_clr);
            underflow <= (rd_en & empty) | (underflow & ~err_clr);
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // head word is always presented; rd_en only pops it
    assign rd_data  = mem[rd_ptr];
    assign rd_valid = ~empty;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) rd_data <= mem[rd_ptr];
        end
    end
`endif
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO; next generation of the team's 8x16 synchronous FIFO.
- Generic data width and depth.
- Concurrent read and write in the same cycle.
- Exposes fill level, programmable almost-full/almost-empty flags, registered read-valid and sticky overflow/underflow error flags.
- Used as the standard buffering element between producer/consumer stages in the same clock domain.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=4.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.
- Local: AW = log2(DEPTH); count is AW+1 bits wide.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- wr_data  in  DATA_W  write data
- rd_en  in  1  read request
- rd_data  out  DATA_W  read data
- rd_valid  out  1  rd_data holds a newly popped word
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- err_clr  in  1  clears overflow/underflow

Behaviour:
- Reset (rst=1 at edge):
  - wr_ptr, rd_ptr and count go to 0; rd_data=0, rd_valid=0, overflow=0, underflow=0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all contents.
  - rst has priority over all other inputs.
- Write accept: wr_acc = wr_en & ~full. On accept, mem[wr_ptr] <= wr_data and wr_ptr increments modulo DEPTH (natural AW-bit wrap).
- Read accept: rd_acc = rd_en & ~empty. On accept, rd_data <= mem[rd_ptr] and rd_ptr increments modulo DEPTH.
- Read latency and rd_valid:
  - Read latency is 1 cycle: data is on rd_data in the cycle after rd_acc, with rd_valid=1 for that single cycle.
  - rd_valid=0 otherwise; rd_data holds its last value.
- count update:
  - wr_acc & ~rd_acc: +1
  - rd_acc & ~wr_acc: -1
  - both or neither: unchanged.
- Simultaneous read and write:
  - Both accepted when 0 < count < DEPTH.
  - When full: the read is accepted, the write is rejected and overflow is set.
  - When empty: the write is accepted, the read is rejected and underflow is set. No bypass of write data to rd_data.
- Status flags:
  - full, empty, almost_full and almost_empty decode combinationally from the registered count. They are therefore valid in the cycle after the causing edge.
- Error flags:
  - overflow sets on wr_en & full; underflow sets on rd_en & empty.
  - Both hold until err_clr=1 or rst.
  - A set condition in the same cycle as err_clr wins: the flag stays 1.
- Rejected requests never modify memory, pointers or count.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - rd_data continuously presents mem[rd_ptr].
  - rd_valid = ~empty, combinational.
  - rd_en acts as a pop/acknowledge, so the head word is visible 0 cycles after it becomes head.
  - A word written into an empty FIFO appears on rd_data the cycle after the write edge.
  - All other rules (acceptance, count, flags, errors) are unchanged.
- Undefined: standard 1-cycle registered read as described above.

Test Plan (DATA_W=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2):
- Reset then idle:
  - Required: count=0, empty=1, almost_empty=1, full=0, rd_valid=0, rd_data=0x00.
- Fill: write 0x00..0x0F on 16 consecutive cycles.
  - Required: almost_empty deasserts after the 3rd write (count=3); almost_full asserts after the 14th; full=1 and count=16 after the 16th.
  - A 17th write (0xAA) sets overflow=1 and leaves count=16.
- Drain: 16 reads.
  - Required: rd_data sequence 0x00..0x0F, each with rd_valid=1 one cycle after rd_en; empty=1 afterwards.
  - An extra read sets underflow=1 and gives rd_valid=0.
- Wrap-around: write 10, read 10, then write 0x30..0x3B (12 words) and read 12.
  - Required: output 0x30..0x3B in order with pointers wrapped; count returns to 0.
- Concurrent access at count=5: assert wr_en and rd_en together for 20 cycles with incrementing data.
  - Required: count stays 5 and output order is preserved.
  - When full with both asserted: count goes to 15 and overflow=1.
  - When empty with both asserted: count goes to 1 and underflow=1.
- Reset mid-op and error clearing: at count=7, assert rst for one cycle.
  - Required: count=0, empty=1, flags cleared.
  - Separately, pulsing err_clr clears a set overflow; err_clr with a simultaneous write-while-full keeps overflow=1.
  - With SYNC_FIFO_FWFT_EN defined: one write of 0x5A to an empty FIFO gives rd_data=0x5A and rd_valid=1 the next cycle with no rd_en.
